// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: execute/memory pipeline bundles,
// the data-bus FSM state encoding and strobe constants.
package memory_stage_pkg;

    typedef logic [31:0] u32;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [3:0]  strobe_t;

    localparam strobe_t STROBE_WORD = 4'b1111;
    localparam strobe_t STROBE_NONE = 4'b0000;

    typedef struct packed {
        u32         alu_result;
        logic       mem_to_reg;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        creg_addr_t rt;
        creg_addr_t rd;
    } execute_data_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        creg_addr_t wa;
        u32         wb_data;
    } memory_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } mem_state_t;

    function automatic creg_addr_t dest_reg(input execute_data_t e);
        return e.reg_dst ? e.rd : e.rt;
    endfunction

endpackage

// File: rtl/memory_stage_mem_fsm.sv
// Request/response sequencer for one data-bus transaction: holds the
// request until the bus accepts it, then waits for the data phase.
module mem_fsm
    import memory_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_issue,
    input  logic       i_addr_ok,
    input  logic       i_data_ok,
    output mem_state_t o_state,
    output logic       o_dreq_valid,
    output logic       o_complete
);

    mem_state_t r_state;
    mem_state_t w_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // data_ok seen outside ADDR/DATA is a protocol violation and is ignored
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (i_issue) w_next = ADDR;
            ADDR: if (i_addr_ok) w_next = i_data_ok ? IDLE : DATA;
            DATA: if (i_data_ok) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_dreq_valid = 1'b0;
        o_complete   = 1'b0;
        case (r_state)
            ADDR: begin
                o_dreq_valid = 1'b1;
                o_complete   = i_addr_ok && i_data_ok;
            end
            DATA: o_complete = i_data_ok;
            default: begin
                o_dreq_valid = 1'b0;
                o_complete   = 1'b0;
            end
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: latches the execute result, runs LW/SW on the
// data bus and hands a write-back bundle to the next stage.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter bit ADDR_ALIGN_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memory_enable,
    input  execute_data_t execute_data_reg,
    input  u32            store_data,
    output logic          dreq_valid,
    output u32            dreq_addr,
    output logic [3:0]    dreq_strobe,
    output u32            dreq_data,
    input  logic          dresp_addr_ok,
    input  logic          dresp_data_ok,
    input  u32            dresp_data,
    output logic          stall,
    output logic          misaligned,
    output memory_data_t  memory_data_reg
);

    execute_data_t r_ex;
    u32            r_store;
    logic          r_pending;
    logic          r_misaligned;
    memory_data_t  r_mem_data;

    mem_state_t    w_state;
    memory_data_t  w_mem_next;
    creg_addr_t    w_wa;
    logic          w_dreq_valid;
    logic          w_complete;
    logic          w_is_mem;
    logic          w_bad_addr;
    logic          w_wen;
    logic          w_idle;
    logic          w_capture;
    logic          w_issue;
    logic          w_trap;
    logic          w_alu_done;

    assign w_is_mem   = r_ex.mem_to_reg | r_ex.mem_write;
    assign w_bad_addr = ADDR_ALIGN_CHECK && (r_ex.alu_result[1:0] != 2'b00);
    assign w_wa       = dest_reg(r_ex);
    assign w_wen      = r_ex.reg_write && (w_wa != '0);
    assign w_idle     = (w_state == IDLE);

    // r_pending marks a latched op the IDLE state has not yet dispatched
    assign stall      = !w_idle || (r_pending && w_is_mem);
    assign w_capture  = memory_enable && !stall;
    assign w_issue    = w_idle && r_pending && w_is_mem && !w_bad_addr;
    assign w_trap     = w_idle && r_pending && w_is_mem && w_bad_addr;
    assign w_alu_done = w_idle && r_pending && !w_is_mem;

    mem_fsm u_fsm (
        .clk          (clk),
        .reset        (reset),
        .i_issue      (w_issue),
        .i_addr_ok    (dresp_addr_ok),
        .i_data_ok    (dresp_data_ok),
        .o_state      (w_state),
        .o_dreq_valid (w_dreq_valid),
        .o_complete   (w_complete)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex      <= '0;
            r_store   <= '0;
            r_pending <= 1'b0;
        end else if (w_capture) begin
            r_ex      <= execute_data_reg;
            r_store   <= store_data;
            r_pending <= 1'b1;
        end else if (w_issue || w_trap || w_alu_done) begin
            r_pending <= 1'b0;
        end
    end

    // stores and trapped accesses never write the register file
    always_comb begin
        w_mem_next = '0;
        if (w_alu_done) begin
            w_mem_next.valid     = 1'b1;
            w_mem_next.reg_write = w_wen;
            w_mem_next.wa        = w_wa;
            w_mem_next.wb_data   = r_ex.alu_result;
        end else if (w_trap) begin
            w_mem_next.valid     = 1'b1;
            w_mem_next.reg_write = 1'b0;
            w_mem_next.wa        = w_wa;
            w_mem_next.wb_data   = r_ex.alu_result;
        end else if (w_complete) begin
            w_mem_next.valid     = 1'b1;
            w_mem_next.reg_write = w_wen && !r_ex.mem_write;
            w_mem_next.wa        = w_wa;
            w_mem_next.wb_data   = r_ex.mem_write ? r_ex.alu_result : dresp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_data   <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_mem_data   <= w_mem_next;
            r_misaligned <= w_trap;
        end
    end

    assign dreq_valid      = w_dreq_valid;
    assign dreq_addr       = w_dreq_valid ? r_ex.alu_result : '0;
    assign dreq_data       = w_dreq_valid ? r_store : '0;
    assign dreq_strobe     = (w_dreq_valid && r_ex.mem_write) ? STROBE_WORD : STROBE_NONE;
    assign misaligned      = r_misaligned;
    assign memory_data_reg = r_mem_data;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: ALU pass-through, LW/SW bus
// handshakes with a programmable-latency responder, traps and reset.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          memory_enable;
    execute_data_t execute_data_reg;
    u32            store_data;
    logic          dreq_valid;
    u32            dreq_addr;
    logic [3:0]    dreq_strobe;
    u32            dreq_data;
    logic          dresp_addr_ok;
    logic          dresp_data_ok;
    u32            dresp_data;
    logic          stall;
    logic          misaligned;
    memory_data_t  memory_data_reg;

    typedef struct {
        logic        regWrite;
        logic [4:0]  wa;
        logic [31:0] data;
        bit          chkData;
        int          expLat;
        int          drvCycle;
    } wbExp_t;

    wbExp_t      expQ[$];
    wbExp_t      monEntry;
    int          vecCount = 0;
    int          errCount = 0;
    int          cycleCnt = 0;
    int          stallCnt = 0;
    int          dreqCnt  = 0;
    int          misCnt   = 0;
    int          wbCnt    = 0;
    int          pushCnt  = 0;
    int          addrDelay = 0;
    int          dataDelay = 0;
    int          busCnt   = 0;
    bit          busPhase = 1'b0;
    bit          forceDataOk = 1'b0;
    logic [31:0] loadData = '0;
    logic [31:0] expAddr  = '0;
    logic [31:0] expData  = '0;
    logic [3:0]  expStrobe = '0;

    memory_stage #(.ADDR_ALIGN_CHECK(1'b1)) dut (
        .clk              (clk),
        .reset            (reset),
        .memory_enable    (memory_enable),
        .execute_data_reg (execute_data_reg),
        .store_data       (store_data),
        .dreq_valid       (dreq_valid),
        .dreq_addr        (dreq_addr),
        .dreq_strobe      (dreq_strobe),
        .dreq_data        (dreq_data),
        .dresp_addr_ok    (dresp_addr_ok),
        .dresp_data_ok    (dresp_data_ok),
        .dresp_data       (dresp_data),
        .stall            (stall),
        .misaligned       (misaligned),
        .memory_data_reg  (memory_data_reg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Bus responder: accepts after addrDelay waiting cycles, completes dataDelay cycles later
    always @(negedge clk) begin
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        if (reset) begin
            busPhase = 1'b0;
            busCnt   = 0;
        end else if (!busPhase) begin
            if (dreq_valid) begin
                if (busCnt == addrDelay) begin
                    dresp_addr_ok = 1'b1;
                    busCnt = 0;
                    if (dataDelay == 0) begin
                        dresp_data_ok = 1'b1;
                        dresp_data    = loadData;
                    end else begin
                        busPhase = 1'b1;
                    end
                end else begin
                    busCnt++;
                end
            end
        end else begin
            if (busCnt + 1 == dataDelay) begin
                dresp_data_ok = 1'b1;
                dresp_data    = loadData;
                busPhase = 1'b0;
                busCnt   = 0;
            end else begin
                busCnt++;
            end
        end
        if (forceDataOk) begin
            dresp_data_ok = 1'b1;
            dresp_data    = 32'hBAD0_BAD0;
            forceDataOk   = 1'b0;
        end
    end

    // Output monitor: request stability, trap pulses and write-back scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (stall) stallCnt++;
            if (dreq_valid) begin
                dreqCnt++;
                checkOutput("dreqAddr", dreq_addr, expAddr);
                checkOutput("dreqStrobe", dreq_strobe, expStrobe);
                if (expStrobe == 4'hF) checkOutput("dreqData", dreq_data, expData);
            end
            if (misaligned) begin
                misCnt++;
                checkOutput("misValid", memory_data_reg.valid, 1'b1);
            end
            if (memory_data_reg.valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spuriousValid", memory_data_reg.valid, 1'b0);
                end else begin
                    monEntry = expQ.pop_front();
                    wbCnt++;
                    checkOutput("wbRegWrite", memory_data_reg.reg_write, monEntry.regWrite);
                    checkOutput("wbWa", memory_data_reg.wa, monEntry.wa);
                    if (monEntry.chkData) checkOutput("wbData", memory_data_reg.wb_data, monEntry.data);
                    if (monEntry.expLat >= 0) checkOutput("wbLatency", cycleCnt - monEntry.drvCycle, monEntry.expLat);
                end
            end
        end
    end

    // Must be called at a falling edge; holds the op until the stage accepts it
    task automatic applyStimulus(input logic [31:0] alu, input logic m2r, input logic mw,
                                 input logic rw, input logic rdst, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [31:0] sd,
                                 input logic [31:0] ld, input int lat, input bit trap);
        wbExp_t e;
        bit     captured = 1'b0;
        execute_data_reg.alu_result = alu;
        execute_data_reg.mem_to_reg = m2r;
        execute_data_reg.mem_write  = mw;
        execute_data_reg.reg_write  = rw;
        execute_data_reg.reg_dst    = rdst;
        execute_data_reg.rt         = rt;
        execute_data_reg.rd         = rd;
        store_data    = sd;
        memory_enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (!stall) begin
                captured = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!captured) begin
            checkOutput("captureTimeout", stall, 1'b0);
        end else begin
            loadData  = ld;
            expAddr   = alu;
            expData   = sd;
            expStrobe = mw ? 4'hF : 4'h0;
            e.wa       = rdst ? rd : rt;
            e.regWrite = rw && (e.wa != 5'd0) && !mw && !trap;
            e.chkData  = !(mw || trap);
            e.data     = m2r ? ld : alu;
            e.expLat   = lat;
            e.drvCycle = cycleCnt;
            expQ.push_back(e);
            pushCnt++;
        end
        @(negedge clk);
        memory_enable = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 300; i++) begin
            if (expQ.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drainTimeout", expQ.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        memory_enable = 1'b0;
        execute_data_reg = '0;
        store_data = '0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data = '0;
        repeat (2) @(negedge clk);
        checkOutput("rstDreqValid", dreq_valid, 1'b0);
        checkOutput("rstDreqAddr", dreq_addr, 32'h0);
        checkOutput("rstDreqStrobe", dreq_strobe, 4'h0);
        checkOutput("rstDreqData", dreq_data, 32'h0);
        checkOutput("rstStall", stall, 1'b0);
        checkOutput("rstMisaligned", misaligned, 1'b0);
        checkOutput("rstMemData", memory_data_reg, '0);
        reset = 1'b0;
        @(negedge clk);

        // ADD into r3, then an ADD targeting r0, then a burst of ALU ops
        stallCnt = 0; dreqCnt = 0;
        applyStimulus(32'h10, 0, 0, 1, 1, 5'd9, 5'd3, 32'h0, 32'h0, 2, 0);
        waitDrain();
        checkOutput("addStall", stallCnt, 0);
        checkOutput("addDreq", dreqCnt, 0);
        applyStimulus(32'h55, 0, 0, 1, 1, 5'd4, 5'd0, 32'h0, 32'h0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($urandom, 0, 0, 1, 0, 5'(i + 1), 5'd0, 32'h0, 32'h0, 2, 0);
        end
        waitDrain();

        // LW with zero-wait bus
        stallCnt = 0; dreqCnt = 0;
        applyStimulus(32'h100, 1, 0, 1, 0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 3, 0);
        waitDrain();
        checkOutput("lwStall", stallCnt, 2);
        checkOutput("lwDreq", dreqCnt, 1);

        // SW with delayed accept and delayed completion
        addrDelay = 3; dataDelay = 2;
        stallCnt = 0; dreqCnt = 0;
        applyStimulus(32'h204, 0, 1, 0, 0, 5'd7, 5'd0, 32'h12345678, 32'h0, 8, 0);
        waitDrain();
        checkOutput("swStall", stallCnt, 7);
        checkOutput("swDreq", dreqCnt, 4);

        // Misaligned LW is trapped without a bus request
        addrDelay = 0; dataDelay = 0;
        dreqCnt = 0;
        applyStimulus(32'h102, 1, 0, 1, 0, 5'd5, 5'd0, 32'h0, 32'h0, 2, 1);
        waitDrain();
        checkOutput("misDreq", dreqCnt, 0);

        // Stray data_ok while idle must not produce a write-back
        forceDataOk = 1'b1;
        repeat (3) @(negedge clk);

        // Stalled LW with enable toggling and garbage inputs, then back-to-back LWs
        addrDelay = 2; dataDelay = 1;
        applyStimulus(32'h400, 1, 0, 1, 0, 5'd10, 5'd0, 32'h0, 32'hA5A5_0001, -1, 0);
        for (int i = 0; i < 50 && stall; i++) begin
            execute_data_reg.alu_result = $urandom;
            execute_data_reg.mem_to_reg = 1'($urandom_range(0, 1));
            execute_data_reg.mem_write  = 1'($urandom_range(0, 1));
            execute_data_reg.rt         = 5'($urandom_range(0, 31));
            execute_data_reg.rd         = 5'($urandom_range(0, 31));
            store_data    = $urandom;
            memory_enable = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        applyStimulus(32'h408, 1, 0, 1, 0, 5'd11, 5'd0, 32'h0, 32'hA5A5_0002, -1, 0);
        applyStimulus(32'h40C, 1, 0, 1, 0, 5'd12, 5'd0, 32'h0, 32'hA5A5_0003, -1, 0);
        waitDrain();

        // Reset while waiting in DATA abandons the load
        addrDelay = 0; dataDelay = 20;
        applyStimulus(32'h300, 1, 0, 1, 0, 5'd6, 5'd0, 32'h0, 32'h77, -1, 0);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midRstDreqValid", dreq_valid, 1'b0);
        checkOutput("midRstDreqAddr", dreq_addr, 32'h0);
        checkOutput("midRstStall", stall, 1'b0);
        checkOutput("midRstMisaligned", misaligned, 1'b0);
        checkOutput("midRstMemData", memory_data_reg, '0);
        expQ.delete();
        pushCnt--;
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        forceDataOk = 1'b1;
        repeat (3) @(negedge clk);
        dataDelay = 0;
        applyStimulus(32'h2A, 0, 0, 1, 1, 5'd0, 5'd8, 32'h0, 32'h0, 2, 0);
        waitDrain();

        checkOutput("wbTotal", wbCnt, pushCnt);
        checkOutput("misTotal", misCnt, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
